// File: rtl/amba_ahb_lite_input_stage.sv
// AHB-Lite master input stage: forwards master address phases to a shared bus, holding one request while the bus is not granted.
// Define AMBA_AHB_LITE_INPUT_STAGE_BYPASS_EN for zero-latency live issue; otherwise every transfer goes through the hold register.
module amba_ahb_lite_input_stage #(
    parameter  int W_ADDR  = 32,
    parameter  int W_DATA  = 32,
    localparam int W_TRANS = 2,
    localparam int W_BURST = 3
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [W_TRANS-1:0] HTRANS,
    input  logic [W_ADDR-1:0]  HADDR,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [W_BURST-1:0] HBURST,
    input  logic [3:0]         HPROT,
    input  logic               HMASTLOCK,
    input  logic [W_DATA-1:0]  HWDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [W_DATA-1:0]  HRDATA,
    output logic               ma_bus_req,
    output logic [W_TRANS-1:0] ma_HTRANS,
    output logic [W_BURST-1:0] ma_HBURST,
    output logic               ma_HMASTLOCK,
    input  logic               ma_active,
    output logic [W_ADDR-1:0]  out_HADDR,
    output logic               out_HWRITE,
    output logic [2:0]         out_HSIZE,
    output logic [3:0]         out_HPROT,
    output logic [W_DATA-1:0]  out_HWDATA,
    input  logic               HREADY,
    input  logic               bus_HRESP,
    input  logic [W_DATA-1:0]  bus_HRDATA
);
    localparam logic [W_TRANS-1:0] TRANS_IDLE = 2'b00;

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_DATA} state_t;

    state_t state, state_n;

    logic [W_TRANS-1:0] hold_trans;
    logic [W_ADDR-1:0]  hold_addr;
    logic               hold_write;
    logic [2:0]         hold_size;
    logic [W_BURST-1:0] hold_burst;
    logic [3:0]         hold_prot;
    logic               hold_lock;

    logic live_path, issue, accept, capture;

`ifdef AMBA_AHB_LITE_INPUT_STAGE_BYPASS_EN
    assign live_path  = (state != ST_PENDING);
    assign ma_bus_req = (state == ST_PENDING) | HTRANS[1] | HMASTLOCK;
`else
    logic bus_req_q;

    assign live_path  = 1'b0;
    assign ma_bus_req = bus_req_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) bus_req_q <= 1'b0;
        else        bus_req_q <= (state_n == ST_PENDING);
    end
`endif

    assign ma_HTRANS    = live_path ? HTRANS    : hold_trans;
    assign out_HADDR    = live_path ? HADDR     : hold_addr;
    assign out_HWRITE   = live_path ? HWRITE    : hold_write;
    assign out_HSIZE    = live_path ? HSIZE     : hold_size;
    assign ma_HBURST    = live_path ? HBURST    : hold_burst;
    assign out_HPROT    = live_path ? HPROT     : hold_prot;
    assign ma_HMASTLOCK = live_path ? HMASTLOCK : hold_lock;
    assign out_HWDATA   = HWDATA;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never reach the bus.
    assign issue   = ma_HTRANS[1] & ma_active & HREADY;
    assign accept  = HTRANS[1] & HREADYOUT & (state != ST_PENDING);
    assign capture = accept & ~(live_path & issue);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        state_n   = state;
        case (state)
            ST_IDLE: begin
                if (issue)        state_n = ST_DATA;
                else if (capture) state_n = ST_PENDING;
            end
            ST_PENDING: begin
                HREADYOUT = 1'b0;
                if (issue) state_n = ST_DATA;
            end
            ST_DATA: begin
                HREADYOUT = HREADY;
                HRESP     = bus_HRESP;
                HRDATA    = bus_HRDATA;
                if (HREADY) begin
                    if (issue)        state_n = ST_DATA;
                    else if (capture) state_n = ST_PENDING;
                    else              state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= ST_IDLE;
        else        state <= state_n;
    end

    // NOTE: the hold register is reset so a discarded request can never resurface on the bus.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hold_trans <= TRANS_IDLE;
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_size  <= '0;
            hold_burst <= '0;
            hold_prot  <= '0;
            hold_lock  <= 1'b0;
        end else if (capture) begin
            hold_trans <= HTRANS;
            hold_addr  <= HADDR;
            hold_write <= HWRITE;
            hold_size  <= HSIZE;
            hold_burst <= HBURST;
            hold_prot  <= HPROT;
            hold_lock  <= HMASTLOCK;
        end else if (issue && !live_path) begin
            // The held request has gone out; keep the registered bus view idle.
            hold_trans <= TRANS_IDLE;
        end
    end

endmodule
